// File: rtl/rpm_rx_parser_pkg.sv
// Shared constants for the RPM frame link: ASCII bytes, node numbers,
// parser state and location-prefix encodings.
package rpm_rx_parser_pkg;

  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_X    = 8'h58;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_3    = 8'h33;

  // Node numbers shared with the transmitter side
  localparam logic [4:0] PSU1 = 5'd27;
  localparam logic [4:0] PSU2 = 5'd29;
  localparam logic [4:0] PSU3 = 5'd31;
  localparam logic [4:0] SU1  = 5'd5;
  localparam logic [4:0] SU2  = 5'd4;
  localparam logic [4:0] SU3  = 5'd3;
  localparam logic [4:0] FSU1 = 5'd25;
  localparam logic [4:0] FSU2 = 5'd22;
  localparam logic [4:0] FSU3 = 5'd20;
  localparam logic [4:0] WSU1 = 5'd17;
  localparam logic [4:0] WSU2 = 5'd15;
  localparam logic [4:0] WSU3 = 5'd13;

  localparam logic [1:0] ERR_CHAR    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_H1, S_H2, S_H3, S_L0, S_L1, S_L2, S_L3,
    S_X1, S_X2, S_DASH, S_HASH
  } state_t;

  typedef enum logic [1:0] {
    PFX_NONE = 2'd0,
    PFX_P    = 2'd1,
    PFX_F    = 2'd2,
    PFX_W    = 2'd3
  } prefix_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_1) && (c <= CH_3);
  endfunction

endpackage

// File: rtl/rpm_rx_parser_if.sv
// Byte-in / result-out bundle between the UART RX, the parser and the
// pick/route controller.
interface rpm_rx_parser_if;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       msg_valid;
  logic [4:0] node;
  logic       node_known;
  logic       err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output rx_msg, rx_complete,
    input  msg_valid, node, node_known, err, err_code, busy
  );

  modport slave (
    input  rx_msg, rx_complete,
    output msg_valid, node, node_known, err, err_code, busy
  );
endinterface

// File: rtl/rpm_rx_parser_loc_decode.sv
// Location decode: (prefix, digit 1..3) -> pick node number.
module rpm_loc_decode
  import rpm_rx_parser_pkg::*;
(
  input  prefix_t    prefix,
  input  logic [1:0] digit,
  output logic [4:0] node
);

  always_comb begin
    node = '0;
    case ({prefix, digit})
      {PFX_P,    2'd1}: node = PSU1;
      {PFX_P,    2'd2}: node = PSU2;
      {PFX_P,    2'd3}: node = PSU3;
      {PFX_NONE, 2'd1}: node = SU1;
      {PFX_NONE, 2'd2}: node = SU2;
      {PFX_NONE, 2'd3}: node = SU3;
      {PFX_F,    2'd1}: node = FSU1;
      {PFX_F,    2'd2}: node = FSU2;
      {PFX_F,    2'd3}: node = FSU3;
      {PFX_W,    2'd1}: node = WSU1;
      {PFX_W,    2'd2}: node = WSU2;
      {PFX_W,    2'd3}: node = WSU3;
      default:          node = '0;
    endcase
  end

endmodule

// File: rtl/rpm_rx_parser.sv
// Parses "RPM-<loc>-#" frames from the UART RX byte stream into a node
// number pulse, with error pulses for bad bytes and inter-byte timeouts.
module rpm_rx_parser
  import rpm_rx_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2_500_000,
  parameter int TO_W        = 22
) (
  input logic           clk,
  input logic           rst_n,
  rpm_rx_parser_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  prefix_t         prefix;
  logic [1:0]      digit;
  logic            known_pend;
  logic [TO_W-1:0] to_cnt;
  logic            msg_valid;
  logic [4:0]      node;
  logic            node_known;
  logic            err;
  logic [1:0]      err_code;
  logic [4:0]      dec_node;
  logic            accept;
  logic [7:0]      rx;

  assign rx = bus.rx_msg;

  rpm_loc_decode u_loc_decode (
    .prefix (prefix),
    .digit  (digit),
    .node   (dec_node)
  );

  // Is the byte on rx legal for the current state? IDLE takes anything and
  // simply ignores non-'R' bytes.
  always_comb begin
    accept = 1'b0;
    case (state)
      S_IDLE: accept = 1'b1;
      S_H1:   accept = (rx == CH_P);
      S_H2:   accept = (rx == CH_M);
      S_H3:   accept = (rx == CH_DASH);
      S_L0:   accept = (rx == CH_P) || (rx == CH_F) || (rx == CH_W) ||
                       (rx == CH_S) || (rx == CH_X);
      S_L1:   accept = (rx == CH_S);
      S_L2:   accept = (rx == CH_U);
      S_L3:   accept = is_digit(rx);
      S_X1:   accept = (rx == CH_X);
      S_X2:   accept = (rx == CH_X);
      S_DASH: accept = (rx == CH_DASH);
      S_HASH: accept = (rx == CH_HASH);
      default: accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prefix     <= PFX_NONE;
      digit      <= '0;
      known_pend <= 1'b0;
      to_cnt     <= '0;
      msg_valid  <= 1'b0;
      node       <= '0;
      node_known <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      msg_valid <= 1'b0;
      err       <= 1'b0;
      if (bus.rx_complete) begin
        // A byte always beats a coincident timeout expiry
        to_cnt <= '0;
        if (!accept) begin
          err      <= 1'b1;
          err_code <= ERR_CHAR;
          state    <= (rx == CH_R) ? S_H1 : S_IDLE;
        end else begin
          case (state)
            S_IDLE: if (rx == CH_R) state <= S_H1;
            S_H1:   state <= S_H2;
            S_H2:   state <= S_H3;
            S_H3:   state <= S_L0;
            S_L0: begin
              case (rx)
                CH_P: begin prefix <= PFX_P;    state <= S_L1; end
                CH_F: begin prefix <= PFX_F;    state <= S_L1; end
                CH_W: begin prefix <= PFX_W;    state <= S_L1; end
                CH_S: begin prefix <= PFX_NONE; state <= S_L2; end
                default: state <= S_X1;
              endcase
            end
            S_L1:   state <= S_L2;
            S_L2:   state <= S_L3;
            S_L3: begin
              digit      <= rx[1:0];
              known_pend <= 1'b1;
              state      <= S_DASH;
            end
            S_X1:   state <= S_X2;
            S_X2: begin
              known_pend <= 1'b0;
              state      <= S_DASH;
            end
            S_DASH: state <= S_HASH;
            S_HASH: begin
              msg_valid  <= 1'b1;
              node       <= known_pend ? dec_node : 5'd0;
              node_known <= known_pend;
              state      <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end else if (state == S_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        state    <= S_IDLE;
        to_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign bus.msg_valid  = msg_valid;
  assign bus.node       = node;
  assign bus.node_known = node_known;
  assign bus.err        = err;
  assign bus.err_code   = err_code;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_rpm_rx_parser.sv
// Scoreboard bench for rpm_rx_parser: expected pulses are queued as frames
// are driven and matched against msg_valid/err as they appear.
module tb_rpm_rx_parser;

  logic clk;
  logic rst_n;

  rpm_rx_parser_if bus ();

  rpm_rx_parser #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit is_err;
    int node;
    bit known;
    int code;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_msg(input int node, input bit known);
    exp_t e;
    e.is_err = 1'b0; e.node = node; e.known = known; e.code = 0;
    sb.push_back(e);
  endtask

  task automatic push_err(input int code);
    exp_t e;
    e.is_err = 1'b1; e.node = 0; e.known = 1'b0; e.code = code;
    sb.push_back(e);
  endtask

  // Caller is always #1 after a posedge; the strobe is sampled at the next one.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_msg      = b;
    bus.rx_complete = 1'b1;
    @(posedge clk); #1;
    bus.rx_complete = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic drain(input string tag);
    repeat (4) begin @(posedge clk); #1; end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (bus.msg_valid || bus.err) begin
      if (bus.msg_valid && bus.err) chk("excl", 1, 0);
      if (sb.size() == 0) begin
        chk("spurious", {30'd0, bus.err, bus.msg_valid}, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("kind", int'(bus.err), int'(mon_e.is_err));
        if (!mon_e.is_err) begin
          chk("node", int'(bus.node), mon_e.node);
          chk("node_known", int'(bus.node_known), int'(mon_e.known));
        end else begin
          chk("err_code", int'(bus.err_code), mon_e.code);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    bus.rx_msg      = 8'h00;
    bus.rx_complete = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_msg_valid", int'(bus.msg_valid), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_node", int'(bus.node), 0);
    chk("rst_known", int'(bus.node_known), 0);
    chk("rst_err_code", int'(bus.err_code), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_msg(0, 1'b0);
    send_str("RPM-XXX-#", 1);
    drain("drain_xxx");

    push_msg(29, 1'b1);
    send_str("RPM-PSU2-#", 4);
    drain("drain_psu2");

    push_msg(3, 1'b1);
    push_msg(17, 1'b1);
    send_str("RPM-SU3-#", 0);
    send_str("RPM-WSU1-#", 0);
    drain("drain_b2b");

    push_err(1);
    send_str("RPM-Q", 2);
    chk("hold_node", int'(bus.node), 17);
    chk("hold_known", int'(bus.node_known), 1);
    chk("hold_err_code", int'(bus.err_code), 1);
    chk("idle_after_err", int'(bus.busy), 0);
    push_msg(20, 1'b1);
    send_str("RPM-FSU3-#", 0);
    drain("drain_fsu3");

    push_err(1);
    push_msg(25, 1'b1);
    send_str("RPRPM-FSU1-#", 0);
    drain("drain_resync");

    push_err(2);
    send_str("RPM", 1);
    send_byte(8'h2D, 16);
    chk("to_busy", int'(bus.busy), 0);
    chk("to_err_code", int'(bus.err_code), 2);
    drain("drain_timeout");

    push_msg(27, 1'b1);
    send_str("RPM", 1);
    send_byte(8'h2D, 15);
    chk("busy_mid", int'(bus.busy), 1);
    send_str("PSU1-#", 1);
    drain("drain_expiry");

    send_str("RPM-PS", 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_node", int'(bus.node), 0);
    chk("mrst_known", int'(bus.node_known), 0);
    chk("mrst_err_code", int'(bus.err_code), 0);
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_msg_valid", int'(bus.msg_valid), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_msg(27, 1'b1);
    send_str("RPM-PSU1-#", 1);
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
